// File: rtl/vrs_pkg.sv
// Shared types and rate-code constants for the variable-rate-shading blocks.
package vrs_pkg;

  localparam logic [1:0] VRS_RATE_1 = 2'b00;
  localparam logic [1:0] VRS_RATE_2 = 2'b01;
  localparam logic [1:0] VRS_RATE_4 = 2'b10;

  localparam int VRS_RATE_BITS = 4;

  // One shading-rate map entry; rx occupies the upper two bits.
  typedef struct packed {
    logic [1:0] rx;
    logic [1:0] ry;
  } vrs_rate_t;

endpackage

// File: rtl/vrs_rate_store.sv
// Single-port synchronous shading-rate map storage with registered read data.
module vrs_rate_store
  import vrs_pkg::*;
#(
  parameter int DEPTH  = 2304,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  vrs_rate_t         wdata,
  output vrs_rate_t         rdata
);

  vrs_rate_t mem [DEPTH];

  // One access per enabled cycle: write, or read into the output register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/vrs_rate_arbiter.sv
// Shading-rate map access arbiter: round-robin tile reads, prioritised
// command-processor updates with a starvation bound, tagged 2-cycle responses.
module vrs_rate_arbiter
  import vrs_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAP_W         = 64,
  parameter int MAP_H         = 36,
  parameter int TILE_W_LOG2   = 1,
  parameter int TILE_H_LOG2   = 1,
  parameter int ADDR_W        = 12,
  parameter int UPD_BURST_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [16*NUM_REQ-1:0]      req_x,
  input  logic [16*NUM_REQ-1:0]      req_y,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [1:0]                 rsp_rx,
  output logic [1:0]                 rsp_ry,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [ADDR_W-1:0]          upd_addr,
  input  logic [3:0]                 upd_data
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = MAP_W * MAP_H;
  localparam int CNT_W = $clog2(UPD_BURST_MAX + 1);

  function automatic logic [15:0] clamp_tile(input logic [15:0] pix,
                                             input int shift,
                                             input int lim);
    logic [15:0] t;
    t = pix >> shift;
    if (t > 16'(lim)) t = 16'(lim);
    return t;
  endfunction

  // Code 11 is not a legal rate; it saturates to the coarsest rate.
  function automatic logic [1:0] sat_rate(input logic [1:0] c);
    return (c == 2'b11) ? VRS_RATE_4 : c;
  endfunction

  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;
  logic               any_req;
  logic               force_read;
  logic               rd_gnt;
  logic               upd_in_map;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    rr_nxt;
  logic [15:0]        sel_x;
  logic [15:0]        sel_y;
  logic [15:0]        tile_x;
  logic [15:0]        tile_y;
  logic [ADDR_W-1:0]  rd_idx;

  logic               vld_p0;
  logic               en_p0;
  logic               we_p0;
  logic [ADDR_W-1:0]  addr_p0;
  vrs_rate_t          wdata_p0;
  logic [ID_W-1:0]    id_p0;
  logic               map_en_p0;

  logic               vld_p1;
  logic [ID_W-1:0]    id_p1;
  logic               map_en_p1;
  vrs_rate_t          srm_rdata;

  // Arbitration: update priority, forced read at the burst bound, round-robin pick.
  always_comb begin
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    int                   sum;
    dbl    = {req_valid, req_valid} >> rr_ptr;
    rot    = dbl[NUM_REQ-1:0];
    found  = 1'b0;
    sum    = 0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = k + int'(rr_ptr);
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        gnt_id = ID_W'(sum);
      end
    end
    any_req    = |req_valid;
    force_read = any_req && (burst_cnt == CNT_W'(UPD_BURST_MAX));
    upd_ready  = !rst && upd_valid && !force_read;
    rd_gnt     = !rst && any_req && !(upd_valid && !force_read);
    req_ready  = rd_gnt ? (NUM_REQ'(1) << gnt_id) : '0;
    rr_nxt     = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    upd_in_map = int'(upd_addr) < DEPTH;
  end

  // Pixel-to-tile translation of the granted requester, clamped to the map edge.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        sel_x = req_x[16*k +: 16];
        sel_y = req_y[16*k +: 16];
      end
    end
    tile_x = clamp_tile(sel_x, TILE_W_LOG2, MAP_W - 1);
    tile_y = clamp_tile(sel_y, TILE_H_LOG2, MAP_H - 1);
    rd_idx = ADDR_W'(tile_y) * ADDR_W'(MAP_W) + ADDR_W'(tile_x);
  end

  // Round-robin pointer and update-burst counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      if (rd_gnt) rr_ptr <= rr_nxt;
      if (rd_gnt || !any_req) begin
        burst_cnt <= '0;
      end else if (upd_ready) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
    end
  end

  // ---- Stage p0: the granted access (read or write) is registered and
  // performed on the SRM in the following cycle, so the single port never
  // sees two accesses in one cycle and a later read always follows the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      en_p0  <= 1'b0;
      we_p0  <= 1'b0;
    end else begin
      vld_p0 <= rd_gnt;
      we_p0  <= upd_ready && upd_in_map;
      en_p0  <= (rd_gnt && cfg_enable) || (upd_ready && upd_in_map);
    end
  end

  // Stage p0 data capture.
  always_ff @(posedge clk) begin
    if (rd_gnt) begin
      addr_p0   <= rd_idx;
      id_p0     <= gnt_id;
      map_en_p0 <= cfg_enable;
    end else if (upd_ready) begin
      addr_p0  <= upd_addr;
      wdata_p0 <= vrs_rate_t'(upd_data);
    end
  end

  vrs_rate_store #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .en    (en_p0),
    .we    (we_p0),
    .addr  (addr_p0),
    .wdata (wdata_p0),
    .rdata (srm_rdata)
  );

  // ---- Stage p1: response tag travels alongside the SRM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) id_p1 <= id_p0;
    end
  end

  // Stage p1 data capture.
  always_ff @(posedge clk) begin
    if (vld_p0) map_en_p1 <= map_en_p0;
  end

  // ---- Response: rate fields are zero unless a map-enabled read is returning.
  always_comb begin
    rsp_valid = vld_p1;
    rsp_id    = id_p1;
    rsp_rx    = VRS_RATE_1;
    rsp_ry    = VRS_RATE_1;
    if (vld_p1 && map_en_p1) begin
      rsp_rx = sat_rate(srm_rdata.rx);
      rsp_ry = sat_rate(srm_rdata.ry);
    end
  end

endmodule

// File: tb/tb_vrs_rate_arbiter.sv
// Directed bench for vrs_rate_arbiter with a response scoreboard.
module tb_vrs_rate_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_rx;
  logic [1:0]  rsp_ry;
  logic        upd_valid;
  logic        upd_ready;
  logic [11:0] upd_addr;
  logic [3:0]  upd_data;

  logic [15:0] px [4];
  logic [15:0] py [4];
  logic [3:0]  model [2304];
  logic [5:0]  sbq [$];
  int          total = 0;
  int          bad = 0;

  assign req_x = {px[3], px[2], px[1], px[0]};
  assign req_y = {py[3], py[2], py[1], py[0]};

  vrs_rate_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_enable (cfg_enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_rx     (rsp_rx),
    .rsp_ry     (rsp_ry),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_addr   (upd_addr),
    .upd_data   (upd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: pixel -> clamped tile -> map entry -> saturated rate, tagged.
  function automatic logic [5:0] exp_rsp(input int id, input logic [15:0] x,
                                         input logic [15:0] y, input logic en);
    int tx;
    int ty;
    logic [3:0] c;
    logic [1:0] rx;
    logic [1:0] ry;
    tx = int'(x >> 1);
    ty = int'(y >> 1);
    if (tx > 63) tx = 63;
    if (ty > 35) ty = 35;
    c  = model[ty * 64 + tx];
    rx = c[3:2];
    ry = c[1:0];
    if (rx == 2'b11) rx = 2'b10;
    if (ry == 2'b11) ry = 2'b10;
    if (!en) begin
      rx = 2'b00;
      ry = 2'b00;
    end
    return {id[1:0], rx, ry};
  endfunction

  // Scoreboard: compare responses, record grants and map writes.
  always @(negedge clk) begin
    if (rsp_valid) begin
      chk("rsp_pending", 32'(sbq.size() != 0), 32'(1));
      if (sbq.size() != 0) chk("rsp", 32'({rsp_id, rsp_rx, rsp_ry}), 32'(sbq.pop_front()));
    end
    if (rst) begin
      sbq.delete();
    end else begin
      chk("rdy_rules", 32'({(req_ready & ~req_valid) != 4'b0, upd_ready && !upd_valid,
                            $countones(req_ready) > 1, (|req_ready) && upd_ready}), 32'(0));
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && req_valid[i]) sbq.push_back(exp_rsp(i, px[i], py[i], cfg_enable));
      end
      if (upd_ready && upd_valid && upd_addr < 12'd2304) model[upd_addr] <= upd_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input int a, input logic [3:0] d);
    int n;
    n = 0;
    upd_addr  = 12'(a);
    upd_data  = d;
    upd_valid = 1'b1;
    @(negedge clk);
    while (!upd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("upd_hs", 32'(upd_ready), 32'(1));
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    px[i] = x;
    py[i] = y;
    req_valid = 4'(1 << i);
    @(negedge clk);
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_hs", 32'(req_ready), 32'(1 << i));
    tick();
    req_valid = 4'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'(0));
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    cfg_enable = 1'b1;
    req_valid  = 4'b0;
    upd_valid  = 1'b0;
    upd_addr   = '0;
    upd_data   = '0;
    for (int i = 0; i < 4; i++) begin
      px[i] = '0;
      py[i] = '0;
    end
    tick();
    tick();

    // Readies held low during reset even with requests present.
    req_valid = 4'hF;
    upd_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_upd_ready", 32'(upd_ready), 32'(0));
    tick();
    rst       = 1'b0;
    req_valid = 4'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_rx", 32'(rsp_rx), 32'(0));
    chk("rst_rsp_ry", 32'(rsp_ry), 32'(0));
    tick();

    // Round-robin fairness from reset.
    do_upd(10, 4'b0001);
    do_upd(11, 4'b0110);
    do_upd(12, 4'b1001);
    do_upd(13, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      px[i] = 16'(2 * (10 + i));
      py[i] = 16'd0;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_order", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
    end
    req_valid = 4'b0;
    drain();

    // Single read right after its write, with exact latency.
    do_upd(130, 4'b0110);
    px[0] = 16'd5;
    py[0] = 16'd5;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rd130_gnt", 32'(req_ready), 32'(1));
    tick();
    req_valid = 4'b0;
    @(negedge clk);
    chk("rd130_lat1", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk("rd130_lat2", 32'(rsp_valid), 32'(1));
    chk("rd130_data", 32'({rsp_id, rsp_rx, rsp_ry}), 32'(6'b00_01_10));
    tick();

    // Update priority and starvation bound.
    px[2] = 16'd22;
    py[2] = 16'd0;
    upd_addr  = 12'd200;
    upd_data  = 4'b0101;
    upd_valid = 1'b1;
    req_valid = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stv_upd", 32'(upd_ready), 32'(k != 4));
      chk("stv_rd", 32'(req_ready), (k == 4) ? 32'(4) : 32'(0));
      tick();
    end
    upd_valid = 1'b0;
    req_valid = 4'b0;
    drain();
    do_read(1, 16'd16, 16'd6);
    drain();

    // Edge clamping and out-of-range update.
    do_upd(2303, 4'b1001);
    do_read(1, 16'hFFFF, 16'hFFFF);
    drain();
    do_upd(2304, 4'b0011);
    do_read(2, 16'hFFFF, 16'hFFFF);
    drain();

    // Disabled map: enable sampled at grant, no SRM enable.
    do_upd(300, 4'b1010);
    cfg_enable = 1'b0;
    do_read(3, 16'd88, 16'd8);
    cfg_enable = 1'b1;
    @(negedge clk);
    chk("dis_srm_en", 32'(dut.u_store.en), 32'(0));
    drain();
    do_read(3, 16'd88, 16'd8);
    drain();

    // Reset one cycle after a grant discards the read and the pointer.
    px[1] = 16'd22;
    py[1] = 16'd0;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("mid_gnt", 32'(req_ready), 32'(2));
    tick();
    req_valid = 4'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_norsp", 32'(rsp_valid), 32'(0));
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      px[i] = 16'(2 * (10 + i));
      py[i] = 16'd0;
    end
    req_valid = 4'hF;
    @(negedge clk);
    chk("mid_rr_reset", 32'(req_ready), 32'(1));
    tick();
    req_valid = 4'b0;
    drain();

    chk("final_queue", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
